// File: rtl/thermocouple_spi_responder_pkg.sv
// Shared definitions for the thermocouple SPI responder:
// frame layout, frame width, counter width and FSM state type.
package thermocouple_spi_responder_pkg;

    localparam int FRAME_BITS    = 32;
    localparam int CNT_W         = 6;

    localparam int TC_MSB        = 31;
    localparam int TC_LSB        = 18;
    localparam int RSV_HI_BIT    = 17;
    localparam int FAULT_ANY_BIT = 16;
    localparam int CJ_MSB        = 15;
    localparam int CJ_LSB        = 4;
    localparam int RSV_LO_BIT    = 3;
    localparam int FAULT_MSB     = 2;
    localparam int FAULT_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [13:0] tc,
        input logic [11:0] cj,
        input logic [2:0]  flt
    );
        logic [FRAME_BITS-1:0] f;
        f                   = '0;
        f[TC_MSB:TC_LSB]    = tc;
        f[RSV_HI_BIT]       = 1'b0;
        f[FAULT_ANY_BIT]    = |flt;
        f[CJ_MSB:CJ_LSB]    = cj;
        f[RSV_LO_BIT]       = 1'b0;
        f[FAULT_MSB:FAULT_LSB] = flt;
        return f;
    endfunction

endpackage

// File: rtl/thermocouple_spi_responder_sync.sv
// Multi-flop synchroniser with rise/fall pulses. Edges are
// suppressed until the chain has been refilled after reset.
module spi_edge_sync #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;
    logic [STAGES:0]   warm;

    // Synchronise the input, keep one history flop and track
    // when the chain holds only post-reset samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{IDLE_VAL}};
            hist  <= IDLE_VAL;
            warm  <= '0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            hist <= chain[STAGES-1];
            warm <= {warm[STAGES-1:0], 1'b1};
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = warm[STAGES] & sync & ~hist;
    assign fall = warm[STAGES] & ~sync & hist;

endmodule

// File: rtl/thermocouple_spi_responder.sv
// SPI mode-0 responder that streams a 32-bit thermocouple
// frame snapshot, MSB first, to an external master.
module thermocouple_spi_responder
    import thermocouple_spi_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] tc_temp,
    input  logic [11:0] junction_temp,
    input  logic [2:0]  fault_in,
    input  logic        spi_cs_n,
    input  logic        spi_sck,
    output logic        spi_miso,
    output logic        miso_oe,
    output logic        busy,
    output logic        frame_done
);

    logic cs_sync;
    logic cs_rise;
    logic cs_fall;
    logic sck_level_unused;
    logic sck_rise;
    logic sck_fall;

    state_t                state;
    logic [FRAME_BITS-1:0] shreg;
    logic [CNT_W-1:0]      cnt;

    spi_edge_sync #(
        .STAGES   (SYNC_STAGES),
        .IDLE_VAL (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_cs_n),
        .sync  (cs_sync),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_edge_sync #(
        .STAGES   (SYNC_STAGES),
        .IDLE_VAL (1'b0)
    ) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_sck),
        .sync  (sck_level_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // Frame FSM: snapshot on select, shift on sck falls, count
    // master samples on sck rises, park in DRAIN after 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        shreg <= build_frame(tc_temp,
                                             junction_temp,
                                             fault_in);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sck_rise &&
                        cnt == CNT_W'(FRAME_BITS - 1)) begin
                        frame_done <= 1'b1;
                        cnt        <= cnt + 1'b1;
                        shreg      <= '0;
                        if (cs_rise) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (cs_rise) begin
                        shreg <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        if (sck_rise) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (sck_fall) begin
                            shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cs_rise) begin
                        shreg <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    shreg <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi_miso = shreg[FRAME_BITS-1];
    assign miso_oe  = ~cs_sync;

endmodule

// File: tb/tb_thermocouple_spi_responder.sv
// Randomised self-checking bench for the thermocouple
// SPI responder, acting as an SPI mode-0 master.
module tb_thermocouple_spi_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] tc_temp;
    logic [11:0] junction_temp;
    logic [2:0]  fault_in;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_miso;
    logic        miso_oe;
    logic        busy;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int done_total = 0;

    always #5 clk = ~clk;

    thermocouple_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tc_temp       (tc_temp),
        .junction_temp (junction_temp),
        .fault_in      (fault_in),
        .spi_cs_n      (spi_cs_n),
        .spi_sck       (spi_sck),
        .spi_miso      (spi_miso),
        .miso_oe       (miso_oe),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_total++;
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [13:0] tc,
                                          input logic [11:0] cj,
                                          input logic [2:0]  f);
        logic [31:0] v;
        v = 32'(tc) * 32'd262144
          + (f != 3'b000 ? 32'd65536 : 32'd0)
          + 32'(cj) * 32'd16
          + 32'(f);
        return v;
    endfunction

    task automatic sck_pulse(output logic b);
        b = spi_miso;
        spi_sck = 1'b1;
        repeat (4) @(negedge clk);
        spi_sck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame(input int nbits,
                             input int chg_at,
                             input logic [13:0] chg_tc,
                             input bit cs_last,
                             output logic [63:0] bits,
                             output int dones);
        int d0;
        bits = '0;
        d0 = done_total;
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) tc_temp = chg_tc;
            if (i == 2) chk("busy_mid", 64'(busy), 64'd1);
            bits[63-i] = spi_miso;
            spi_sck = 1'b1;
            if (cs_last && i == nbits - 1) spi_cs_n = 1'b1;
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        dones = done_total - d0;
    endtask

    initial begin
        logic [63:0] bits;
        logic [31:0] exp;
        logic        b;
        int          dn;
        int          d0;

        rst_n = 1'b0;
        spi_cs_n = 1'b1;
        spi_sck = 1'b0;
        tc_temp = 14'h0190;
        junction_temp = 12'h190;
        fault_in = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst_miso", 64'(spi_miso), 64'd0);
        chk("rst_oe", 64'(miso_oe), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // sck activity while deselected
        d0 = done_total;
        for (int i = 0; i < 4; i++) sck_pulse(b);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_miso", 64'(spi_miso), 64'd0);
        chk("idle_done", 64'(done_total - d0), 64'd0);

        // nominal frame
        run_frame(32, -1, 14'h0, 1'b0, bits, dn);
        chk("nom_frame", 64'(bits[63:32]), 64'h0640_1900);
        chk("nom_done", 64'(dn), 64'd1);
        chk("nom_busy_end", 64'(busy), 64'd0);

        // fault frames
        fault_in = 3'b001;
        run_frame(32, -1, 14'h0, 1'b0, bits, dn);
        chk("flt1_b16", 64'(bits[48]), 64'd1);
        chk("flt1_lo", 64'(bits[34:32]), 64'd1);
        chk("flt1_frame", 64'(bits[63:32]),
            64'(model(14'h0190, 12'h190, 3'b001)));
        fault_in = 3'b110;
        run_frame(32, -1, 14'h0, 1'b0, bits, dn);
        chk("flt6_b16", 64'(bits[48]), 64'd1);
        chk("flt6_lo", 64'(bits[34:32]), 64'd6);
        fault_in = 3'b000;

        // snapshot isolation
        run_frame(32, 5, 14'h3FFF, 1'b0, bits, dn);
        chk("snap_tc", 64'(bits[63:50]), 64'h0190);
        chk("snap_done", 64'(dn), 64'd1);
        tc_temp = 14'h0190;

        // abort after 10 bits
        run_frame(10, -1, 14'h0, 1'b0, bits, dn);
        chk("abort_done", 64'(dn), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_miso", 64'(spi_miso), 64'd0);
        chk("abort_bits", 64'(bits[63:54]),
            64'(model(14'h0190, 12'h190, 3'b000) >> 22));
        run_frame(32, -1, 14'h0, 1'b0, bits, dn);
        chk("post_abort", 64'(bits[63:32]), 64'h0640_1900);

        // overclocked frame
        junction_temp = 12'hA5C;
        run_frame(40, -1, 14'h0, 1'b0, bits, dn);
        chk("ovr_frame", 64'(bits[63:32]),
            64'(model(14'h0190, 12'hA5C, 3'b000)));
        chk("ovr_tail", 64'(bits[31:24]), 64'd0);
        chk("ovr_done", 64'(dn), 64'd1);

        // cs rise together with the 32nd sck rise
        run_frame(32, -1, 14'h0, 1'b1, bits, dn);
        chk("sim_done", 64'(dn), 64'd1);
        chk("sim_busy", 64'(busy), 64'd0);

        // randomised frames
        for (int k = 0; k < 8; k++) begin
            tc_temp = 14'($urandom);
            junction_temp = 12'($urandom);
            fault_in = 3'($urandom_range(0, 7));
            exp = model(tc_temp, junction_temp, fault_in);
            run_frame(32, -1, 14'h0, 1'b0, bits, dn);
            chk("rnd_frame", 64'(bits[63:32]), 64'(exp));
            chk("rnd_done", 64'(dn), 64'd1);
        end

        // reset mid-frame, released with cs held low
        tc_temp = 14'h1234;
        junction_temp = 12'h321;
        fault_in = 3'b010;
        d0 = done_total;
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 20; i++) sck_pulse(b);
        rst_n = 1'b0;
        #1;
        chk("mrst_miso", 64'(spi_miso), 64'd0);
        chk("mrst_oe", 64'(miso_oe), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(frame_done), 64'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rel_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) sck_pulse(b);
        chk("rel_busy2", 64'(busy), 64'd0);
        chk("rel_miso", 64'(spi_miso), 64'd0);
        chk("rel_done", 64'(done_total - d0), 64'd0);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        run_frame(32, -1, 14'h0, 1'b0, bits, dn);
        chk("rel_frame", 64'(bits[63:32]),
            64'(model(14'h1234, 12'h321, 3'b010)));
        chk("rel_fdone", 64'(dn), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/thermocouple_spi_responder.md
THERMOCOUPLE_SPI_RESPONDER -- requirements
Module: thermocouple_spi_responder

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth for spi_cs_n and spi_sck.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; every flop is clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port tc_temp, input, 14 bits: thermocouple temperature to report (signed, 0.25 C/LSB).
REQ-005 The block SHALL have port junction_temp, input, 12 bits: cold-junction temperature to report (signed, 0.0625 C/LSB).
REQ-006 The block SHALL have port fault_in, input, 3 bits: {scv, scg, oc} fault flags.
REQ-007 The block SHALL have port spi_cs_n, input, 1 bit: chip select from the SPI master, asynchronous to clk.
REQ-008 The block SHALL have port spi_sck, input, 1 bit: serial clock from the master (idle low), asynchronous to clk.
REQ-009 The block SHALL have port spi_miso, output, 1 bit: serial data to the master.
REQ-010 The block SHALL have port miso_oe, output, 1 bit: output enable, equal to the synchronised chip select inverted.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a frame is active.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when all 32 bits have been sampled by the master.

Function
REQ-013 The frame SHALL be 32 bits, transmitted MSB first, with these fields:
  - [31:18] tc_temp
  - [17] 0
  - [16] OR of fault_in
  - [15:4] junction_temp
  - [3] 0
  - [2:0] fault_in
REQ-014 spi_cs_n and spi_sck SHALL each pass through a SYNC_STAGES-flop synchroniser; all edge detection SHALL use the synchronised values plus one history flop.
REQ-015 The FSM SHALL have the states IDLE, SHIFT and DRAIN.
REQ-016 In IDLE, a synchronised cs_n falling edge SHALL do three things in the same cycle:
  - load the frame snapshot into a 32-bit shift register;
  - clear the bit counter;
  - go to SHIFT.
REQ-017 Input changes after the snapshot cycle SHALL NOT affect the frame in flight.
REQ-018 spi_miso SHALL equal shift register bit 31 from the cycle after the load.
REQ-019 In SHIFT, each synchronised sck rising edge SHALL increment a 6-bit sample counter.
REQ-020 In SHIFT, each synchronised sck falling edge SHALL shift the register left by one and fill with 0.
REQ-021 On the 32nd sck rising edge, frame_done SHALL pulse for exactly one cycle and the FSM SHALL go to DRAIN.
REQ-022 In DRAIN, spi_miso SHALL be 0 regardless of further sck edges, and the counter SHALL not wrap.
REQ-023 A synchronised cs_n rising edge in SHIFT or DRAIN SHALL return the FSM to IDLE.
REQ-024 If that cs_n rising edge occurs in SHIFT (mid-frame abort), frame_done SHALL NOT pulse.
REQ-025 If a cs_n rising edge and the 32nd sck rising edge occur in the same cycle, frame_done SHALL pulse and the FSM SHALL go to IDLE.
REQ-026 sck edges while in IDLE SHALL be ignored.
REQ-027 spi_miso SHALL be 0 in IDLE.
REQ-028 busy SHALL be high in SHIFT and DRAIN.
REQ-029 A new cs_n falling edge SHALL be required to start each frame; back-to-back frames SHALL need cs_n high for at least one synchronised cycle.

Reset
REQ-030 While rst_n is low, the following SHALL hold asynchronously:
  - FSM = IDLE;
  - shift register = 0 and counter = 0;
  - spi_miso, miso_oe, busy and frame_done = 0;
  - synchroniser flops = idle values (cs_n 1, sck 0).
REQ-031 Reset deassertion while cs_n is already low SHALL NOT start a frame; a fresh cs_n falling edge SHALL be required.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse.

Structure
REQ-033 A shared package SHALL hold:
  - the frame field bit positions;
  - FRAME_BITS = 32;
  - the FSM state enum.
REQ-034 One sub-module, spi_edge_sync, SHALL provide a synchroniser with rise/fall pulse outputs; it SHALL be instantiated twice, once for cs_n and once for sck.

Verification
REQ-035 Nominal frame: tc_temp=14'h0190, junction_temp=12'h190, fault_in=0, then cs_n low and 32 sck periods of 8 clk each -> master samples 32'h0640_1900, frame_done pulses once, busy falls after cs_n rises.
REQ-036 Fault frame: fault_in=3'b001 -> sampled bit 16 = 1 and bits [2:0] = 001; fault_in=3'b110 -> bit 16 = 1 and bits [2:0] = 110.
REQ-037 Snapshot: change tc_temp from 14'h0190 to 14'h3FFF after bit 5 -> frame still reads 14'h0190 in [31:18].
REQ-038 Abort: raise cs_n after 10 bits -> no frame_done, FSM IDLE, spi_miso 0; the next full frame is correct.
REQ-039 Overclock: 40 sck edges in one frame -> frame_done exactly once and bits 33-40 read 0.
REQ-040 Reset: assert rst_n low at bit 20 -> all outputs 0 immediately; release with cs_n held low -> no frame until cs_n toggles high then low.
